// File: rtl/median_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : median_uart_tx
//  Description : Buffers median words in a small FIFO and serializes each one
//                as a start / LSB-first data / stop frame on a UART line.
//  Revision    : 1.0  initial release
// ============================================================================
module median_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         median,
  input  logic                          data_vld,
  input  logic                          clr_ovf,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int c_aw = $clog2(FIFO_DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam int c_bw = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int c_pw = $clog2(CLKS_PER_BIT);

  localparam logic [c_cw-1:0] c_depth    = c_cw'(FIFO_DEPTH);
  localparam logic [c_bw-1:0] c_bit_last = c_bw'(DATA_WIDTH - 1);
  localparam logic [c_pw-1:0] c_clk_last = c_pw'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]       r_wr_ptr, r_rd_ptr;
  logic [c_cw-1:0]       r_count;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
  logic [c_bw-1:0]       r_bit_cnt, w_bit_nxt;
  logic [c_pw-1:0]       r_clk_cnt, w_clk_nxt;
  logic                  r_tx, w_tx_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_ovf;
  logic                  w_pop, w_push, w_drop, w_period_end;

  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign w_push       = data_vld && ((r_count < c_depth) || w_pop);
  assign w_drop       = data_vld && !w_push;
  assign w_period_end = (r_clk_cnt == c_clk_last);

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit_cnt;
    w_clk_nxt   = r_clk_cnt;
    w_tx_nxt    = r_tx;
    w_busy_nxt  = r_busy;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
        w_clk_nxt  = '0;
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rd_ptr];
          w_bit_nxt   = '0;
          w_tx_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_period_end) begin
          w_clk_nxt   = '0;
          w_tx_nxt    = r_shift[0];
          w_state_nxt = S_DATA;
        end else begin
          w_clk_nxt = r_clk_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (w_period_end) begin
          w_clk_nxt = '0;
          if (r_bit_cnt == c_bit_last) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_STOP;
          end else begin
            w_shift_nxt = r_shift >> 1;
            w_tx_nxt    = w_shift_nxt[0];
            w_bit_nxt   = r_bit_cnt + 1'b1;
          end
        end else begin
          w_clk_nxt = r_clk_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (w_period_end) begin
          w_clk_nxt   = '0;
          w_tx_nxt    = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_clk_nxt = r_clk_cnt + 1'b1;
        end
      end
      default: begin
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
        w_clk_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_clk_cnt <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_clk_cnt <= w_clk_nxt;
      r_tx      <= w_tx_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A drop on the same edge as a clear keeps the flag set.
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= median;
  end

  assign tx         = r_tx;
  assign tx_busy    = r_busy;
  assign fifo_count = r_count;
  assign overflow   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_median_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_median_uart_tx
//  Description : Randomized bench for median_uart_tx against a frame-timing
//                reference model and a UART receiver.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_median_uart_tx;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CPB   = 4;
  localparam int FRAME = (DW + 2) * CPB;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] median;
  logic          data_vld;
  logic          clr_ovf;
  logic          tx;
  logic          tx_busy;
  logic [2:0]    fifo_count;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;

  median_uart_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .median     (median),
    .data_vld   (data_vld),
    .clr_ovf    (clr_ovf),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: a queue of buffered words plus a countdown of frame cycles.
  logic [DW-1:0] m_q [$];
  logic [DW-1:0] rx_exp [$];
  logic [DW-1:0] m_cur;
  int            m_rem;
  logic          m_ovf;
  logic          m_pop, m_acc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      rx_exp.delete();
      m_rem = 0;
      m_ovf = 1'b0;
      m_cur = '0;
    end else begin
      m_pop = (m_rem == 0) && (m_q.size() > 0);
      m_acc = data_vld && ((m_q.size() < DEPTH) || m_pop);
      if (m_pop) begin
        m_cur = m_q.pop_front();
        rx_exp.push_back(m_cur);
        m_rem = FRAME;
      end else if (m_rem > 0) begin
        m_rem--;
      end
      if (m_acc) m_q.push_back(median);
      if (data_vld && !m_acc) m_ovf = 1'b1;
      else if (clr_ovf)       m_ovf = 1'b0;
    end
  end

  function automatic logic exp_tx();
    int slot;
    if (m_rem == 0) return 1'b1;
    slot = (FRAME - m_rem) / CPB;
    if (slot == 0)  return 1'b0;
    if (slot > DW)  return 1'b1;
    return m_cur[slot-1];
  endfunction

  // Per-cycle output checks and a mid-bit sampling receiver.
  logic          rx_act = 1'b0;
  int            rx_idx;
  logic [DW-1:0] rx_byte;
  logic [DW-1:0] rx_want;
  int            peak = 0;

  always @(negedge clk) begin
    if (!rst) begin
      rx_act = 1'b0;
    end else begin
      check_eq("tx", tx, exp_tx());
      check_eq("tx_busy", tx_busy, m_rem != 0);
      check_eq("fifo_count", fifo_count, m_q.size());
      check_eq("overflow", overflow, m_ovf);
      if (fifo_count > peak) peak = fifo_count;
      if (!rx_act) begin
        if (tx == 1'b0) begin
          rx_act  = 1'b1;
          rx_idx  = 0;
          rx_byte = '0;
        end
      end else begin
        rx_idx++;
        if (rx_idx >= CPB + 2 && rx_idx <= CPB * DW + 2 && ((rx_idx - CPB - 2) % CPB) == 0)
          rx_byte[(rx_idx - CPB - 2) / CPB] = tx;
        if (rx_idx == CPB * (DW + 1) + 2) begin
          check_eq("rx_stop", tx, 1'b1);
          if (rx_exp.size() == 0) begin
            check_eq("rx_unexpected_frame", 1, 0);
          end else begin
            rx_want = rx_exp.pop_front();
            check_eq("rx_byte", rx_byte, rx_want);
          end
          rx_act = 1'b0;
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    data_vld = 1'b1;
    median   = w;
    tick();
    data_vld = 1'b0;
  endtask

  initial begin
    bit found;
    rst = 1'b0; data_vld = 1'b0; median = '0; clr_ovf = 1'b0;
    tick(3);
    check_eq("reset_tx", tx, 1'b1);
    check_eq("reset_busy", tx_busy, 1'b0);
    check_eq("reset_count", fifo_count, 0);
    check_eq("reset_ovf", overflow, 1'b0);
    rst = 1'b1;

    // Single word; the frame starts one edge after the push.
    push_word(8'hA5);
    check_eq("a5_count_before_pop", fifo_count, 1);
    tick();
    check_eq("a5_start_tx", tx, 1'b0);
    check_eq("a5_start_busy", tx_busy, 1'b1);
    tick(FRAME + 8);

    // Burst of six: the sixth is dropped.
    peak = 0;
    for (int i = 1; i <= 6; i++) begin
      data_vld = 1'b1;
      median   = DW'(i);
      tick();
    end
    data_vld = 1'b0;
    check_eq("burst_ovf", overflow, 1'b1);
    check_eq("burst_peak", peak, DEPTH);
    tick(5 * (FRAME + 1) + 10);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check_eq("burst_ovf_cleared", overflow, 1'b0);

    // Full FIFO with a push on the exact edge that pops.
    for (int i = 0; i < 5; i++) push_word(8'h10 + DW'(i));
    check_eq("full_count", fifo_count, DEPTH);
    found = 1'b0;
    for (int i = 0; i < 4 * FRAME && !found; i++) begin
      if (m_rem == 0 && m_q.size() > 0) found = 1'b1;
      else tick();
    end
    check_eq("fullpop_found", found, 1'b1);
    push_word(8'h77);
    check_eq("fullpop_count", fifo_count, DEPTH);
    check_eq("fullpop_ovf", overflow, 1'b0);
    tick(5 * (FRAME + 1) + 10);

    // Clear coinciding with a drop loses to the drop.
    for (int i = 0; i < 5; i++) push_word(8'h20 + DW'(i));
    clr_ovf = 1'b1;
    push_word(8'h99);
    check_eq("clr_with_drop", overflow, 1'b1);
    tick();
    clr_ovf = 1'b0;
    check_eq("clr_without_drop", overflow, 1'b0);
    tick(5 * (FRAME + 1) + 10);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      data_vld = ($urandom_range(0, 3) == 0);
      median   = DW'($urandom);
      clr_ovf  = ($urandom_range(0, 15) == 0);
      tick();
    end
    data_vld = 1'b0;
    clr_ovf  = 1'b0;
    tick(5 * (FRAME + 1) + 10);
    check_eq("random_drained", fifo_count, 0);

    // Reset during data bit 3 of 8'h3C.
    push_word(8'h3C);
    push_word(8'h3D);
    push_word(8'h3E);
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if (m_rem == FRAME - 4 * CPB - 2 && m_cur == 8'h3C) found = 1'b1;
      else tick();
    end
    check_eq("bit3_found", found, 1'b1);
    check_eq("bit3_tx_before_reset", tx, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_eq("async_reset_tx", tx, 1'b1);
    check_eq("async_reset_busy", tx_busy, 1'b0);
    check_eq("async_reset_count", fifo_count, 0);
    tick(2);
    rst = 1'b1;
    tick(FRAME);
    check_eq("post_reset_idle_tx", tx, 1'b1);
    check_eq("post_reset_idle_busy", tx_busy, 1'b0);

    // Push accepted on the first edge after release.
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    push_word(8'h5A);
    check_eq("first_edge_push", fifo_count, 1);
    tick(FRAME + 8);

    check_eq("rx_all_frames_seen", rx_exp.size(), 0);
    check_eq("rx_idle_at_end", rx_act, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/median_uart_tx.md
MEDIAN_UART_TX -- requirements
Module: median_uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of median word and of serialized payload.
REQ-002 Parameter FIFO_DEPTH, default 4, number of median words buffered (power of two, >=2).
REQ-003 Parameter CLKS_PER_BIT, default 4, clock cycles per serial bit period (>=2).
REQ-004 clk  input  1  single system clock, all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset; rst=0 resets immediately, release is synchronous to clk.
REQ-006 median  input  DATA_WIDTH  median result from the upstream median calculator.
REQ-007 data_vld  input  1  median valid strobe; each clk cycle sampled high is one word.
REQ-008 clr_ovf  input  1  synchronous clear of overflow flag.
REQ-009 tx  output  1  serial line, idle high, 8N1-style frame (1 start, DATA_WIDTH data LSB first, 1 stop).
REQ-010 tx_busy  output  1  high while a frame is on the line.
REQ-011 fifo_count  output  $clog2(FIFO_DEPTH)+1  words currently buffered.
REQ-012 overflow  output  1  sticky flag, a word was dropped.

Function
REQ-013 Push: on a rising edge with data_vld=1, median SHALL be written to FIFO tail if count<FIFO_DEPTH or a pop occurs on that same edge; otherwise word dropped and overflow set.
REQ-014 FIFO SHALL be strictly in-order; read/write pointers wrap modulo FIFO_DEPTH; simultaneous push and pop leaves fifo_count unchanged.
REQ-015 FSM states IDLE, START, DATA, STOP; tx and tx_busy SHALL be registered outputs.
REQ-016 IDLE: tx=1, tx_busy=0; on an edge where fifo_count>0, pop head into shift register, clear bit counter, go START (tx=0, tx_busy=1 from that edge).
REQ-017 START: hold tx=0 for CLKS_PER_BIT cycles, then DATA driving bit 0.
REQ-018 DATA: drive shift-register bits LSB first, each for CLKS_PER_BIT cycles; after bit DATA_WIDTH-1 go STOP.
REQ-019 STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE; frame length exactly (DATA_WIDTH+2)*CLKS_PER_BIT cycles; minimum 1 idle cycle between frames.
REQ-020 Latency: word pushed at edge E with FIFO empty and FSM in IDLE SHALL start its frame (tx falls) at edge E+1.
REQ-021 data_vld while busy SHALL only buffer; transmitting word is unaffected by new input.
REQ-022 overflow set by any drop; cleared by clr_ovf=1; set wins when drop and clr_ovf coincide.
REQ-023 Bit-period counter width $clog2(CLKS_PER_BIT), no wrap beyond CLKS_PER_BIT-1.

Reset
REQ-024 While rst=0: tx=1, tx_busy=0, fifo_count=0, overflow=0, FSM=IDLE, pointers and counters 0.
REQ-025 Reset mid-frame SHALL abort the frame, return tx high asynchronously, and discard all buffered words.
REQ-026 First push accepted on the first rising edge after rst returns high.

Verification (DATA_WIDTH=8, FIFO_DEPTH=4, CLKS_PER_BIT=4)
REQ-027 Single word: median=8'hA5 one-cycle data_vld at edge E -> tx=0 cycles E+1..E+4, then bits 1,0,1,0,0,1,0,1 (4 cycles each), stop high 4 cycles; tx_busy high exactly 40 cycles.
REQ-028 Burst: 6 consecutive data_vld cycles, values 01..06 -> 06 dropped, overflow=1, fifo_count peaks 4, line emits 01,02,03,04,05 in order, each 40-cycle frame with 1 idle cycle between.
REQ-029 Full plus pop: FIFO at 4 during a frame, data_vld asserted on the exact edge IDLE pops -> word accepted, fifo_count stays 4, overflow stays 0.
REQ-030 Reset mid-frame: rst=0 during DATA bit 3 of 8'h3C -> tx=1 and tx_busy=0 immediately, fifo_count=0; after release no frame until new data_vld.
REQ-031 Overflow clear: clr_ovf=1 on an edge with a drop -> overflow remains 1; clr_ovf=1 next edge without drop -> overflow=0.
REQ-032 Bench SHALL decode tx with a reference receiver and compare against a queue of accepted medians, checking fifo_count each cycle.
